axi_llc_miss_retire: RTL and testbench
======================================

// Module: axi_llc_miss_retire
// PURPOSE
// - Decrement side of the miss-pipeline descriptor counters. Collects "descriptor left miss
//   pipeline" events from the read unit and write unit, which can both retire in one cycle.
// - Serialises them into at most one cnt_down event per cycle toward the per-ID miss counters.
// - Buffers bursts in per-source FIFOs. Applies backpressure to a retiring unit only when its FIFO is full.
// PARAMETERS
// - IdWidth    4  width of the retired descriptor AXI ID (slave-side ID)
// - FifoDepth  4  entries per source FIFO; >= 1, any value (elaboration assertion)
// PORTS
// - clk_i              in   1        clock, rising edge
// - rst_ni             in   1        reset, synchronous, active-low
// - rd_done_valid_i    in   1        read unit retires a descriptor
// - rd_done_id_i       in   IdWidth  ID of retired read descriptor
// - rd_done_ready_o    out  1        read retire FIFO can accept
// - wr_done_valid_i    in   1        write unit retires a descriptor
// - wr_done_id_i       in   IdWidth  ID of retired write descriptor
// - wr_done_ready_o    out  1        write retire FIFO can accept
// - cnt_down_valid_o   out  1        decrement event valid (counters always accept, no ready)
// - cnt_down_id_o      out  IdWidth  ID to decrement
// - cnt_down_rw_o      out  1        0: read, 1: write (write also decrements write counter)
// - pending_o          out  $clog2(2*FifoDepth+1)  entries buffered in both FIFOs
// - idle_o             out  1        both FIFOs empty
// BEHAVIOUR
// - Reset is synchronous, active-low, on clk_i.
//   - While rst_ni==0 at an edge, both FIFOs are emptied, pending_o=0, and the arbiter pointer is set to READ.
//   - During the reset cycle, ready_o=0 and cnt_down_valid_o=0.
//   - A reset in the middle of a burst drops every buffered event without emitting it. The miss counters are reset in the same cycle.
// - Output values after reset: rd/wr_done_ready_o=1, cnt_down_valid_o=0, cnt_down_id_o=0, cnt_down_rw_o=0,
//   pending_o=0, idle_o=1.
// - Push:
//   - An entry is pushed into a FIFO when valid_i && ready_o at a clock edge.
//   - ready_o = !full and depends only on state. A push into a full FIFO is not allowed in the same cycle as a pop (no pass-through).
// - Latency:
//   - An event accepted at edge N is visible on cnt_down_*_o at the earliest in cycle N+1. There is no combinational bypass.
// - Output:
//   - cnt_down_valid_o = rd FIFO non-empty || wr FIFO non-empty.
//   - id and rw come from the head of the granted FIFO. The granted head is popped at the same edge.
//   - When cnt_down_valid_o=0, id and rw are driven 0.
// - Arbitration (1-bit pointer, states READ/WRITE):
//   - Only one FIFO non-empty: that FIFO is granted. The pointer does not change.
//   - Both FIFOs non-empty: the FIFO named by the pointer is granted. The pointer then flips to the other source (round-robin).
//   - No source starves. Each FIFO waits at most 1 cycle per grant when both are busy.
// - Ordering: within each source, events leave in acceptance order (FIFO). Write ordering is preserved.
// - Push and pop of the same FIFO in one cycle (not full): both take effect, occupancy unchanged.
// - Pointers wrap modulo FifoDepth, which need not be a power of 2.
// - pending_o is registered.
//   - It changes by the number of pushes minus the number of pops at the edge: +2, +1, 0, -1, or at most one pop.
//   - It never exceeds 2*FifoDepth and never underflows.
// - idle_o = (pending_o == 0).
// - Assertions:
//   - No cnt_down_valid_o while idle_o.
//   - A push into a full FIFO is flagged as an error.
//   - pending_o equals the sum of the two FIFO occupancies.
// TESTING
// - Reset:
//   - Stimulus: hold rst_ni=0 for 2 cycles, then release.
//   - Required: ready_o=0/0 during reset, then 1/1; cnt_down_valid_o=0; pending_o=0; idle_o=1.
// - Single read:
//   - Stimulus: rd id=3 at edge 0.
//   - Required: cycle 1 shows valid=1, id=3, rw=0; cycle 2 shows valid=0, idle_o=1.
// - Simultaneous retire:
//   - Stimulus: rd id=1 and wr id=2 at edge 0, pointer READ.
//   - Required: cycle 1 shows id=1 rw=0; cycle 2 shows id=2 rw=1; pending_o goes 2, 1, 0.
// - Fill, FifoDepth=4:
//   - Stimulus: wr ids 0,1,2,3 in 4 consecutive cycles while rd keeps its FIFO busy.
//   - Required: wr_done_ready_o=0 once the write FIFO holds 4 entries; write ids emerge 0,1,2,3 in order.
// - Fairness:
//   - Stimulus: both sources push every cycle for 20 cycles.
//   - Required: output alternates rw=0,1,0,1...; each FIFO saturates; pending_o never exceeds 8.
// - Reset mid-burst:
//   - Stimulus: pending_o=5, then rst_ni=0 for 1 cycle.
//   - Required: next cycle pending_o=0 and valid=0; none of the 5 events is ever emitted.

Source files
------------

// File: rtl/axi_llc_miss_retire.sv
// Merges read/write "descriptor retired" events into one decrement stream for the per-ID miss counters.
// Latency >= 1 cycle through per-source FIFOs; a source sees ready low only while its own FIFO is full.

// Small synchronous FIFO: depth need not be a power of two, no pass-through when full.
// Latency 1 cycle push-to-head; push must not be asserted while full_o.
module axi_llc_miss_retire_fifo #(
    parameter int unsigned Width = 4,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_inc(wptr_q);
            if (pop_i)  rptr_q <= ptr_inc(rptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is deliberately not reset; the head is only consumed when cnt_q says it is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
endmodule

module axi_llc_miss_retire #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned FifoDepth = 4,
    parameter int unsigned PendW     = $clog2(2 * FifoDepth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rd_done_valid_i,
    input  logic [IdWidth-1:0] rd_done_id_i,
    output logic               rd_done_ready_o,
    input  logic               wr_done_valid_i,
    input  logic [IdWidth-1:0] wr_done_id_i,
    output logic               wr_done_ready_o,
    output logic               cnt_down_valid_o,
    output logic [IdWidth-1:0] cnt_down_id_o,
    output logic               cnt_down_rw_o,
    output logic [PendW-1:0]   pending_o,
    output logic               idle_o
);
    localparam int unsigned CntW = $clog2(FifoDepth + 1);

    if (FifoDepth < 1) begin : g_bad_depth
        $error("FifoDepth must be >= 1");
    end

    typedef enum logic {
        ARB_READ  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_e;

    arb_e             arb_q, arb_d;
    logic [PendW-1:0] pending_q, pending_d;

    logic               rd_push, wr_push, rd_pop, wr_pop;
    logic               rd_full, wr_full, rd_empty, wr_empty;
    logic [IdWidth-1:0] rd_head, wr_head;
    logic [CntW-1:0]    rd_cnt, wr_cnt;
    logic               grant_wr;

    axi_llc_miss_retire_fifo #(.Width(IdWidth), .Depth(FifoDepth), .CntW(CntW)) u_rd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rd_push),
        .data_i  (rd_done_id_i),
        .pop_i   (rd_pop),
        .data_o  (rd_head),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .count_o (rd_cnt)
    );

    axi_llc_miss_retire_fifo #(.Width(IdWidth), .Depth(FifoDepth), .CntW(CntW)) u_wr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_push),
        .data_i  (wr_done_id_i),
        .pop_i   (wr_pop),
        .data_o  (wr_head),
        .full_o  (wr_full),
        .empty_o (wr_empty),
        .count_o (wr_cnt)
    );

    // Ready is gated by reset so nothing is accepted in the cycle the FIFOs are being cleared.
    assign rd_done_ready_o = rst_ni && !rd_full;
    assign wr_done_ready_o = rst_ni && !wr_full;
    assign rd_push = rd_done_valid_i && rd_done_ready_o;
    assign wr_push = wr_done_valid_i && wr_done_ready_o;

    assign grant_wr = !wr_empty && (rd_empty || arb_q == ARB_WRITE);
    assign cnt_down_valid_o = rst_ni && (!rd_empty || !wr_empty);
    assign rd_pop = cnt_down_valid_o && !grant_wr;
    assign wr_pop = cnt_down_valid_o && grant_wr;

    assign cnt_down_id_o = !cnt_down_valid_o ? '0 : (grant_wr ? wr_head : rd_head);
    assign cnt_down_rw_o = cnt_down_valid_o && grant_wr;

    always_comb begin
        arb_d = arb_q;
        if (!rd_empty && !wr_empty && cnt_down_valid_o) begin
            arb_d = grant_wr ? ARB_READ : ARB_WRITE;
        end
        pending_d = pending_q + PendW'(rd_push) + PendW'(wr_push)
                  - PendW'(rd_pop) - PendW'(wr_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            arb_q     <= ARB_READ;
            pending_q <= '0;
        end else begin
            arb_q     <= arb_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign idle_o    = (pending_q == '0);

    a_no_valid_when_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(cnt_down_valid_o && idle_o));
    a_no_push_full_rd: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_push && rd_full));
    a_no_push_full_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_push && wr_full));
    a_pending_sum: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pending_q == PendW'(rd_cnt) + PendW'(wr_cnt));
endmodule

// File: tb/tb_axi_llc_miss_retire.sv
// Random and directed retire traffic checked every cycle against a queue-based model of the merger.
module tb_axi_llc_miss_retire;
    localparam int IdW = 4;
    localparam int D   = 4;
    localparam int PW  = $clog2(2 * D + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rd_vld = 1'b0, wr_vld = 1'b0;
    logic [IdW-1:0] rd_id = '0, wr_id = '0;
    logic           rd_rdy, wr_rdy, dn_vld, dn_rw, idle;
    logic [IdW-1:0] dn_id;
    logic [PW-1:0]  pending;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: one queue of IDs per source plus "whose turn" when both wait.
    logic [IdW-1:0] mq_rd [$];
    logic [IdW-1:0] mq_wr [$];
    bit             turn_wr = 1'b0;

    axi_llc_miss_retire #(.IdWidth(IdW), .FifoDepth(D)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .rd_done_valid_i  (rd_vld),
        .rd_done_id_i     (rd_id),
        .rd_done_ready_o  (rd_rdy),
        .wr_done_valid_i  (wr_vld),
        .wr_done_id_i     (wr_id),
        .wr_done_ready_o  (wr_rdy),
        .cnt_down_valid_o (dn_vld),
        .cnt_down_id_o    (dn_id),
        .cnt_down_rw_o    (dn_rw),
        .pending_o        (pending),
        .idle_o           (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check outputs against the model, then advance the model.
    task automatic cycle(input bit rst, input bit rv, input logic [IdW-1:0] ri,
                         input bit wv, input logic [IdW-1:0] wi);
        bit             e_rrdy, e_wrdy, e_vld, e_rw, both;
        logic [IdW-1:0] e_id;
        int             occ;
        @(negedge clk);
        rst_n = rst; rd_vld = rv; rd_id = ri; wr_vld = wv; wr_id = wi;
        #1;
        occ    = mq_rd.size() + mq_wr.size();
        e_rrdy = rst && mq_rd.size() < D;
        e_wrdy = rst && mq_wr.size() < D;
        e_vld  = rst && occ > 0;
        both   = mq_rd.size() > 0 && mq_wr.size() > 0;
        e_rw   = e_vld && (mq_rd.size() == 0 || (both && turn_wr));
        e_id   = '0;
        if (e_vld) e_id = e_rw ? mq_wr[0] : mq_rd[0];
        check("rd_ready", 32'(rd_rdy), 32'(e_rrdy));
        check("wr_ready", 32'(wr_rdy), 32'(e_wrdy));
        check("valid",    32'(dn_vld), 32'(e_vld));
        check("id",       32'(dn_id),  32'(e_id));
        check("rw",       32'(dn_rw),  32'(e_rw));
        check("pending",  32'(pending), 32'(occ));
        check("idle",     32'(idle),   32'(occ == 0));
        if (!rst) begin
            mq_rd.delete();
            mq_wr.delete();
            turn_wr = 1'b0;
        end else begin
            if (e_vld) begin
                if (e_rw) void'(mq_wr.pop_front());
                else      void'(mq_rd.pop_front());
                if (both) turn_wr = !e_rw;
            end
            if (rv && e_rrdy) mq_rd.push_back(ri);
            if (wv && e_wrdy) mq_wr.push_back(wi);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        @(posedge clk);
        // Reset held for two checked cycles.
        cycle(1'b0, 1'b1, 4'd5, 1'b1, 4'd6);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        idle_cycles(1);
        // Single read.
        cycle(1'b1, 1'b1, 4'd3, 1'b0, '0);
        idle_cycles(2);
        // Simultaneous retire with pointer on READ.
        cycle(1'b1, 1'b1, 4'd1, 1'b1, 4'd2);
        idle_cycles(3);
        // Fill the write FIFO while reads keep arriving.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, IdW'(i + 8), 1'b1, IdW'(i));
        idle_cycles(12);
        // Fairness: both sources push every cycle.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b1, IdW'($urandom), 1'b1, IdW'($urandom));
        idle_cycles(12);
        // Build up pending=5 then reset mid-burst.
        for (int i = 0; i < 30 && (mq_rd.size() + mq_wr.size()) != 5; i++)
            cycle(1'b1, 1'b1, IdW'($urandom), 1'b1, IdW'($urandom));
        check("burst_pending5", 32'(mq_rd.size() + mq_wr.size()), 32'd5);
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
        idle_cycles(3);
        // Random traffic at varying densities with rare resets.
        for (int ph = 0; ph < 4; ph++) begin
            int pct;
            pct = 20 + ph * 25;
            for (int i = 0; i < 400; i++)
                cycle($urandom_range(0, 63) != 0,
                      $urandom_range(0, 99) < pct, IdW'($urandom),
                      $urandom_range(0, 99) < pct, IdW'($urandom));
            idle_cycles(10);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
